alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
// - Initiator side of the ALU operand/opcode interface: accepts commands over valid/ready,
//   drives registered operands and opcode into a combinational ALU, waits a settle time,
//   captures the 2*WIDTH-bit result and returns it over a valid/ready response channel.
// - Sits between a command source (test controller / CPU-lite datapath) and the ALU; optional
//   accumulate mode feeds the previous result back as operand A.
// PARAMETERS
// - WIDTH          4   operand width; ALU result and response are 2*WIDTH bits
// - SETTLE_CYCLES  1   cycles operands are held before capture; legal 1..15
// PORTS
// - i_clk        in   1          clock, rising edge
// - i_rst        in   1          asynchronous reset, active-high
// - i_cmd_valid  in   1          command present
// - o_cmd_ready  out  1          sequencer can accept a command (high only in IDLE)
// - i_cmd_op     in   3          opcode: 000 A, 001 A+B, 010 A-B, 011 A<<1, 100 A>>1, 101 A>B, 110/111 -> 0
// - i_cmd_a      in   WIDTH      operand A
// - i_cmd_b      in   WIDTH      operand B
// - i_cmd_acc    in   1          1: operand A = acc_q[WIDTH-1:0] instead of i_cmd_a
// - o_alu_a      out  WIDTH      registered operand A to ALU
// - o_alu_b      out  WIDTH      registered operand B to ALU
// - o_alu_s      out  3          registered opcode to ALU
// - i_alu_result in   2*WIDTH    combinational ALU result
// - o_rsp_valid  out  1          response present
// - i_rsp_ready  in   1          response consumer ready
// - o_rsp_data   out  2*WIDTH    captured result
// - o_busy       out  1          state != IDLE
// BEHAVIOUR
// - Interface: one clock, reset is asynchronous and active-high (i_clk, i_rst).
// - Reset (any time, incl. mid-operation): state=IDLE, o_alu_a/b/s=0, acc_q=0, o_rsp_data=0,
//   o_rsp_valid=0, o_busy=0, settle counter=0; in-flight command discarded, no response.
// - FSM IDLE -> ISSUE -> RESP -> IDLE.
//   IDLE: o_cmd_ready=1; on i_cmd_valid&o_cmd_ready at edge E: latch o_alu_a (acc or i_cmd_a),
//   o_alu_b, o_alu_s; load counter=SETTLE_CYCLES-1; go ISSUE.
//   ISSUE: operands held stable; counter decrements each cycle; when counter==0 the edge captures
//   i_alu_result into o_rsp_data and acc_q, go RESP.
//   RESP: o_rsp_valid=1, o_rsp_data stable; on i_rsp_ready go IDLE (o_rsp_valid low next cycle).
// - Latency: accept at edge E -> o_rsp_valid high after edge E+SETTLE_CYCLES.
// - Throughput: one command per SETTLE_CYCLES+2 cycles minimum (no accept in RESP cycle).
// - i_cmd_valid while not ready: ignored, command must be held by source.
// - i_rsp_ready while o_rsp_valid=0: no effect.
// - Accumulate with acc_q wider than WIDTH: upper WIDTH bits of acc_q are dropped for operand A.
// - acc_q updates only on capture; reset value 0, so first acc command uses A=0.
// - ALU result arithmetic (for checking): operands zero-extended to 2*WIDTH before op;
//   A-B wraps modulo 2^(2*WIDTH); A<<1 keeps carried-out bit; A>B yields 1/0.
// CONFIGURATION
// - ALU_CHECK_EN defined: internal golden model computes expected result from latched
//   o_alu_a/b/s using the arithmetic rules above; adds output o_mismatch (1 bit), set at capture
//   edge if i_alu_result != expected, sticky until reset; reset value 0.
// - ALU_CHECK_EN undefined: no model, no o_mismatch port; all other behaviour identical.
// TESTING (WIDTH=4, SETTLE_CYCLES=1 unless stated)
// - Reset: assert i_rst mid-ISSUE -> o_busy=0, o_rsp_valid=0, o_cmd_ready=1, o_alu_*=0 immediately.
// - Add: op=001 A=4'h9 B=4'h8 -> o_rsp_data=8'h11 valid one edge after ISSUE edge.
// - Sub wrap: op=010 A=3 B=5 -> 8'hFE; op=011 A=4'hF -> 8'h1E; op=111 -> 8'h00.
// - Accumulate: op=001 A=2 B=3 (->5), then acc=1 op=001 B=4 -> 8'h09; acc_q low bits used.
// - Backpressure: hold i_rsp_ready=0 10 cycles -> o_rsp_valid/o_rsp_data stable, o_cmd_ready=0.
// - SETTLE_CYCLES=4; with ALU_CHECK_EN, force wrong i_alu_result -> capture after 4 cycles, o_mismatch=1 sticky.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a combinational ALU: latches operands, waits SETTLE_CYCLES, returns the result.
// Define ALU_CHECK_EN to add an internal golden model and the sticky o_mismatch output.
module alu_cmd_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [2:0]           i_cmd_op,
    input  logic [WIDTH-1:0]     i_cmd_a,
    input  logic [WIDTH-1:0]     i_cmd_b,
    input  logic                 i_cmd_acc,
    output logic [WIDTH-1:0]     o_alu_a,
    output logic [WIDTH-1:0]     o_alu_b,
    output logic [2:0]           o_alu_s,
    input  logic [2*WIDTH-1:0]   i_alu_result,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [2*WIDTH-1:0]   o_rsp_data,
    output logic                 o_busy
`ifdef ALU_CHECK_EN
    ,
    output logic                 o_mismatch
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state_q;
    logic [3:0]           cnt_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     alu_a_q;
    logic [WIDTH-1:0]     alu_a_d;
    logic [WIDTH-1:0]     alu_b_q;
    logic [2:0]           alu_s_q;
    logic [2*WIDTH-1:0]   rsp_data_q;
    logic                 rsp_valid_q;
    logic                 busy_q;
    logic                 ready_q;

    // Only the low WIDTH bits of the previous result are kept; they are all operand A can use.
    assign alu_a_d = i_cmd_acc ? acc_q : i_cmd_a;

`ifdef ALU_CHECK_EN
    logic mismatch_q;

    function automatic logic [2*WIDTH-1:0] alu_golden(
        input logic [2:0]       s,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [2*WIDTH-1:0] ax;
        logic [2*WIDTH-1:0] bx;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        case (s)
            3'b000:  alu_golden = ax;
            3'b001:  alu_golden = ax + bx;
            3'b010:  alu_golden = ax - bx;
            3'b011:  alu_golden = ax << 1;
            3'b100:  alu_golden = ax >> 1;
            3'b101:  alu_golden = (2*WIDTH)'(a > b);
            default: alu_golden = '0;
        endcase
    endfunction

    assign o_mismatch = mismatch_q;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
`ifdef ALU_CHECK_EN
            mismatch_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_cmd_valid) begin
                        alu_a_q <= alu_a_d;
                        alu_b_q <= i_cmd_b;
                        alu_s_q <= i_cmd_op;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ISSUE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cnt_q == '0) begin
                        rsp_data_q  <= i_alu_result;
                        acc_q       <= i_alu_result[WIDTH-1:0];
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
`ifdef ALU_CHECK_EN
                        if (i_alu_result != alu_golden(alu_s_q, alu_a_q, alu_b_q)) begin
                            mismatch_q <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = ready_q;
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_s     = alu_s_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: instance 0 settles 1 cycle, instance 1 settles 4 cycles.
// A cycle-level transaction model is compared against both instances on every falling edge.
module tb_alu_cmd_sequencer;

    localparam int W  = 4;
    localparam int S0 = 1;
    localparam int S1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       cv   [2];
    logic [2:0] op   [2];
    logic [3:0] ca   [2];
    logic [3:0] cb   [2];
    logic       cacc [2];
    logic       rr   [2];
    logic [7:0] fault[2];

    logic       crdy [2];
    logic       rv   [2];
    logic       bsy  [2];
    logic [3:0] aa   [2];
    logic [3:0] ab   [2];
    logic [2:0] as_  [2];
    logic [7:0] res  [2];
    logic [7:0] rd   [2];
`ifdef ALU_CHECK_EN
    logic       mis  [2];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Reference ALU written with integer arithmetic.
    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        int ai;
        int bi;
        ai = int'(a);
        bi = int'(b);
        case (s)
            3'd0:    return 8'(ai);
            3'd1:    return 8'(ai + bi);
            3'd2:    return 8'(ai - bi);
            3'd3:    return 8'(ai * 2);
            3'd4:    return 8'(ai / 2);
            3'd5:    return (ai > bi) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    assign res[0] = alu_f(as_[0], aa[0], ab[0]) ^ fault[0];
    assign res[1] = alu_f(as_[1], aa[1], ab[1]) ^ fault[1];

    alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S0)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cv[0]), .o_cmd_ready(crdy[0]), .i_cmd_op(op[0]),
        .i_cmd_a(ca[0]), .i_cmd_b(cb[0]), .i_cmd_acc(cacc[0]),
        .o_alu_a(aa[0]), .o_alu_b(ab[0]), .o_alu_s(as_[0]), .i_alu_result(res[0]),
        .o_rsp_valid(rv[0]), .i_rsp_ready(rr[0]), .o_rsp_data(rd[0]), .o_busy(bsy[0])
`ifdef ALU_CHECK_EN
        , .o_mismatch(mis[0])
`endif
    );

    alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S1)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cv[1]), .o_cmd_ready(crdy[1]), .i_cmd_op(op[1]),
        .i_cmd_a(ca[1]), .i_cmd_b(cb[1]), .i_cmd_acc(cacc[1]),
        .o_alu_a(aa[1]), .o_alu_b(ab[1]), .o_alu_s(as_[1]), .i_alu_result(res[1]),
        .o_rsp_valid(rv[1]), .i_rsp_ready(rr[1]), .o_rsp_data(rd[1]), .o_busy(bsy[1])
`ifdef ALU_CHECK_EN
        , .o_mismatch(mis[1])
`endif
    );

    // Transaction model: a command is pending for S edges after acceptance, then its
    // result is offered until the consumer takes it.
    int         m_left [2];
    logic       m_pend [2];
    logic       m_valid[2];
    logic       m_bad  [2];
    logic       m_mis  [2];
    logic [7:0] m_res  [2];
    logic [7:0] m_data [2];
    logic [3:0] m_acc  [2];
    logic [3:0] m_a    [2];
    logic [3:0] m_b    [2];
    logic [2:0] m_s    [2];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_left[k] <= 0;     m_pend[k] <= 1'b0; m_valid[k] <= 1'b0;
                m_bad[k]  <= 1'b0;  m_mis[k]  <= 1'b0; m_res[k]   <= 8'd0;
                m_data[k] <= 8'd0;  m_acc[k]  <= 4'd0; m_a[k]     <= 4'd0;
                m_b[k]    <= 4'd0;  m_s[k]    <= 3'd0;
            end else if (m_valid[k]) begin
                if (rr[k]) m_valid[k] <= 1'b0;
            end else if (m_pend[k]) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) begin
                    m_pend[k]  <= 1'b0;
                    m_valid[k] <= 1'b1;
                    m_data[k]  <= m_res[k];
                    m_acc[k]   <= m_res[k][3:0];
                    if (m_bad[k]) m_mis[k] <= 1'b1;
                end
            end else if (cv[k]) begin
                m_a[k]    <= cacc[k] ? m_acc[k] : ca[k];
                m_b[k]    <= cb[k];
                m_s[k]    <= op[k];
                m_res[k]  <= alu_f(op[k], cacc[k] ? m_acc[k] : ca[k], cb[k]) ^ fault[k];
                m_bad[k]  <= (fault[k] != 8'd0);
                m_pend[k] <= 1'b1;
                m_left[k] <= (k == 0) ? S0 : S1;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("busy",  k, 32'(bsy[k]),  32'(m_pend[k] | m_valid[k]));
            chk("ready", k, 32'(crdy[k]), 32'(!(m_pend[k] | m_valid[k])));
            chk("valid", k, 32'(rv[k]),   32'(m_valid[k]));
            chk("alu_a", k, 32'(aa[k]),   32'(m_a[k]));
            chk("alu_b", k, 32'(ab[k]),   32'(m_b[k]));
            chk("alu_s", k, 32'(as_[k]),  32'(m_s[k]));
            if (m_valid[k]) chk("data", k, 32'(rd[k]), 32'(m_data[k]));
`ifdef ALU_CHECK_EN
            chk("mismatch", k, 32'(mis[k]), 32'(m_mis[k]));
`endif
        end
    end

    task automatic set_cmd(input int k, input logic [2:0] o, input logic [3:0] a,
                           input logic [3:0] b, input logic acc);
        op[k] = o; ca[k] = a; cb[k] = b; cacc[k] = acc; cv[k] = 1'b1;
    endtask

    task automatic wait_accept(input int k);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (crdy[k]) begin
                @(posedge clk);
                #1 cv[k] = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            cv[k] = 1'b0;
            chk("accept_timeout", k, 32'd0, 32'd1);
        end
    endtask

    task automatic send(input int k, input logic [2:0] o, input logic [3:0] a,
                        input logic [3:0] b, input logic acc);
        set_cmd(k, o, a, b, acc);
        wait_accept(k);
    endtask

    // lat < 0 skips the latency check; exp is the hand-computed response word.
    task automatic get_rsp(input int k, input string nm, input logic [7:0] exp,
                           input int hold, input int lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (rv[k]) seen = 1'b1;
        end
        if (!seen) begin
            chk({nm, "_timeout"}, k, 32'd0, 32'd1);
        end else begin
            chk(nm, k, 32'(rd[k]), 32'(exp));
            if (lat >= 0) chk({nm, "_latency"}, k, 32'(n - 1), 32'(lat));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({nm, "_held"}, k, 32'(rd[k]), 32'(exp));
                chk({nm, "_held_rdy"}, k, 32'(crdy[k]), 32'd0);
            end
            rr[k] = 1'b1;
            @(posedge clk);
            #1 rr[k] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            cv[k] = 1'b0; op[k] = 3'd0; ca[k] = 4'd0; cb[k] = 4'd0;
            cacc[k] = 1'b0; rr[k] = 1'b0; fault[k] = 8'd0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 0, 32'(crdy[0]), 32'd1);
        chk("rst_busy",  0, 32'(bsy[0]),  32'd0);
        chk("rst_valid", 0, 32'(rv[0]),   32'd0);
        chk("rst_data",  0, 32'(rd[0]),   32'd0);
        rst = 1'b0;

        send(0, 3'b001, 4'h9, 4'h8, 1'b0); get_rsp(0, "add",     8'h11, 0, S0);
        send(0, 3'b010, 4'h3, 4'h5, 1'b0); get_rsp(0, "sub",     8'hFE, 0, S0);
        send(0, 3'b011, 4'hF, 4'h0, 1'b0); get_rsp(0, "shl",     8'h1E, 0, S0);
        send(0, 3'b111, 4'hF, 4'hF, 1'b0); get_rsp(0, "op7",     8'h00, 0, S0);
        send(0, 3'b110, 4'h5, 4'h2, 1'b0); get_rsp(0, "op6",     8'h00, 0, S0);
        send(0, 3'b000, 4'h7, 4'h1, 1'b0); get_rsp(0, "pass",    8'h07, 0, S0);
        send(0, 3'b100, 4'h9, 4'h0, 1'b0); get_rsp(0, "shr",     8'h04, 0, S0);
        send(0, 3'b101, 4'h9, 4'h3, 1'b0); get_rsp(0, "gt_t",    8'h01, 0, S0);
        send(0, 3'b101, 4'h3, 4'h9, 1'b0); get_rsp(0, "gt_f",    8'h00, 0, S0);
        send(0, 3'b101, 4'h6, 4'h6, 1'b0); get_rsp(0, "gt_eq",   8'h00, 0, S0);

        send(0, 3'b001, 4'h2, 4'h3, 1'b0); get_rsp(0, "acc_0",   8'h05, 0, S0);
        send(0, 3'b001, 4'hF, 4'h4, 1'b1); get_rsp(0, "acc_1",   8'h09, 0, S0);
        send(0, 3'b001, 4'hF, 4'hF, 1'b0); get_rsp(0, "acc_w0",  8'h1E, 0, S0);
        send(0, 3'b000, 4'h0, 4'h0, 1'b1); get_rsp(0, "acc_w1",  8'h0E, 0, S0);

        send(0, 3'b001, 4'h1, 4'h1, 1'b0); get_rsp(0, "bpress",  8'h02, 10, S0);

        // Consumer ready while nothing is offered must not disturb anything.
        rr[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rr[0] = 1'b0;

        // Second command is presented while the first response is still held.
        send(0, 3'b010, 4'h5, 4'h1, 1'b0);
        set_cmd(0, 3'b011, 4'hA, 4'h0, 1'b1);
        get_rsp(0, "ovl_0", 8'h04, 3, S0);
        wait_accept(0);
        get_rsp(0, "ovl_1", 8'h08, 0, -1);

        send(1, 3'b001, 4'h9, 4'h8, 1'b0); get_rsp(1, "s4_add",  8'h11, 2, S1);
`ifdef ALU_CHECK_EN
        fault[1] = 8'h01;
        send(1, 3'b001, 4'h1, 4'h1, 1'b0); get_rsp(1, "s4_bad",  8'h03, 0, S1);
        fault[1] = 8'h00;
        chk("mis_set", 1, 32'(mis[1]), 32'd1);
        send(1, 3'b000, 4'h2, 4'h0, 1'b0); get_rsp(1, "s4_good", 8'h02, 0, S1);
        chk("mis_sticky", 1, 32'(mis[1]), 32'd1);
        chk("mis_clean",  0, 32'(mis[0]), 32'd0);
`endif

        send(1, 3'b001, 4'h3, 4'h3, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy",  1, 32'(bsy[1]),  32'd0);
        chk("arst_valid", 1, 32'(rv[1]),   32'd0);
        chk("arst_ready", 1, 32'(crdy[1]), 32'd1);
        chk("arst_alu_a", 1, 32'(aa[1]),   32'd0);
        chk("arst_alu_b", 1, 32'(ab[1]),   32'd0);
        chk("arst_alu_s", 1, 32'(as_[1]),  32'd0);
`ifdef ALU_CHECK_EN
        chk("arst_mis",   1, 32'(mis[1]),  32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        send(1, 3'b001, 4'hF, 4'h1, 1'b1); get_rsp(1, "s4_acc0", 8'h01, 0, S1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
